// File: rtl/bcd_seq_accumulator_7seg_if.sv
// Operand/result handshake bundle for the BCD sequential accumulator.
interface bcd_seq_accumulator_7seg_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  op;
    logic                  clr;
    logic [4*DIGITS-1:0]   operand;
    logic [4*DIGITS-1:0]   acc;
    logic                  carry;
    logic                  err;
    logic                  out_valid;

    modport master (
        output in_valid, op, clr, operand,
        input  in_ready, acc, carry, err, out_valid
    );

    modport slave (
        input  in_valid, op, clr, operand,
        output in_ready, acc, carry, err, out_valid
    );
endinterface

// File: rtl/bcd_seq_accumulator_7seg.sv
// N-digit BCD add/subtract accumulator (one digit per clock, LSD first)
// with a free-running multiplexed 7-segment scan of the committed value.
module bcd_seq_accumulator_7seg #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    bcd_seq_accumulator_7seg_if.slave  bus,
    output logic [6:0]                 seg,
    output logic [DIGITS-1:0]          an
);

    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   w_q, w_d;
    logic [DW-1:0]   opd_q, opd_d;
    logic            op_q, op_d;
    logic            c_q, c_d;
    logic            carry_q, carry_d;
    logic            err_q, err_d;
    logic            ov_q, ov_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]   scan_idx_q, scan_idx_d;

    logic [3:0]      w_dig, d_dig, sum_dig;
    logic [4:0]      dsum;
    logic            c_out;
    logic            opd_bad;
    logic [DW-1:0]   acc_sh;

    // Ready only when idle and not being cleared this cycle
    assign bus.in_ready  = (state_q == S_IDLE) && !bus.clr;
    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.err       = err_q;
    assign bus.out_valid = ov_q;

    // Flag any non-BCD digit in the incoming operand
    always_comb begin
        opd_bad = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (bus.operand[4*k +: 4] > 4'd9) begin
                opd_bad = 1'b1;
            end
        end
    end

    // One decimal digit step; subtraction uses nines' complement with carry-in 1
    always_comb begin
        w_dig = w_q[3:0];
        d_dig = op_q ? 4'(4'd9 - opd_q[3:0]) : opd_q[3:0];
        dsum  = 5'(w_dig) + 5'(d_dig) + 5'(c_q);
        if (dsum > 5'd9) begin
            sum_dig = 4'(dsum - 5'd10);
            c_out   = 1'b1;
        end else begin
            sum_dig = dsum[3:0];
            c_out   = 1'b0;
        end
    end

    // FSM next-state and datapath updates; W and operand rotate right one digit per step
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        w_d     = w_q;
        opd_d   = opd_q;
        op_d    = op_q;
        c_d     = c_q;
        carry_d = carry_q;
        err_d   = err_q;
        ov_d    = 1'b0;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.clr) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                end else if (bus.in_valid) begin
                    opd_d = bus.operand;
                    op_d  = bus.op;
                    w_d   = acc_q;
                    idx_d = '0;
                    c_d   = bus.op;
                    if (opd_bad) begin
                        err_d   = 1'b1;
                        ov_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                w_d   = (w_q >> 4) | (DW'(sum_dig) << (DW - 4));
                opd_d = opd_q >> 4;
                c_d   = c_out;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(DIGITS - 1)) begin
                    acc_d   = w_d;
                    carry_d = op_q ? ~c_out : c_out;
                    err_d   = 1'b0;
                    ov_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Display scan counter and digit index, independent of the FSM
    always_comb begin
        scan_cnt_d = scan_cnt_q + CW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            w_q        <= '0;
            opd_q      <= '0;
            op_q       <= 1'b0;
            c_q        <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            ov_q       <= 1'b0;
            idx_q      <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            w_q        <= w_d;
            opd_q      <= opd_d;
            op_q       <= op_d;
            c_q        <= c_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
            ov_q       <= ov_d;
            idx_q      <= idx_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // Digit select and 7-segment decode of the committed accumulator
    always_comb begin
        acc_sh = acc_q >> {scan_idx_q, 2'b00};
        an     = DIGITS'(1) << scan_idx_q;
        case (acc_sh[3:0])
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: tb/tb_bcd_seq_accumulator_7seg.sv
// Directed bench for bcd_seq_accumulator_7seg (DIGITS=4, SCAN_DIV=4).
module tb_bcd_seq_accumulator_7seg;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;

    int checks = 0;
    int errors = 0;

    bcd_seq_accumulator_7seg_if #(.DIGITS(DIGITS)) bus ();

    bcd_seq_accumulator_7seg #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr_first;
        logic        op;
        logic [15:0] operand;
        logic [15:0] exp_acc;
        logic        exp_carry;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [16];
    logic [6:0] seg_tab [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge where out_valid is seen (or timeout)
    task automatic run_txn(input logic clr_first, input logic op, input logic [15:0] operand,
                           output int lat);
        if (clr_first) begin
            bus.clr = 1'b1;
            #1;
            check("clr_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            bus.clr = 1'b0;
            check("clr_acc", 32'(bus.acc), 32'd0);
            check("clr_carry_err", {30'd0, bus.carry, bus.err}, 32'd0);
            check("clr_out_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.operand  = operand;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Counts out_valid pulses over n cycles
    task automatic count_ov(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        int n;

        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1111011;

        //             clr   op    operand   acc       carry err   lat
        vecs[0]  = '{1'b1, 1'b0, 16'h0009, 16'h0009, 1'b0, 1'b0, 4};
        vecs[1]  = '{1'b0, 1'b0, 16'h0001, 16'h0010, 1'b0, 1'b0, 4};
        vecs[2]  = '{1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0, 1'b0, 4};
        vecs[3]  = '{1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 4};
        vecs[4]  = '{1'b1, 1'b0, 16'h0456, 16'h0456, 1'b0, 1'b0, 4};
        vecs[5]  = '{1'b0, 1'b0, 16'h0544, 16'h1000, 1'b0, 1'b0, 4};
        vecs[6]  = '{1'b1, 1'b0, 16'h0456, 16'h0456, 1'b0, 1'b0, 4};
        vecs[7]  = '{1'b0, 1'b1, 16'h0544, 16'h9912, 1'b1, 1'b0, 4};
        vecs[8]  = '{1'b0, 1'b0, 16'h00A5, 16'h9912, 1'b1, 1'b1, 0};
        vecs[9]  = '{1'b0, 1'b1, 16'hF000, 16'h9912, 1'b1, 1'b1, 0};
        vecs[10] = '{1'b0, 1'b0, 16'h0088, 16'h0000, 1'b1, 1'b0, 4};
        vecs[11] = '{1'b1, 1'b0, 16'h0456, 16'h0456, 1'b0, 1'b0, 4};
        vecs[12] = '{1'b0, 1'b1, 16'h0012, 16'h0444, 1'b0, 1'b0, 4};
        vecs[13] = '{1'b0, 1'b0, 16'h0001, 16'h0445, 1'b0, 1'b0, 4};
        vecs[14] = '{1'b0, 1'b1, 16'h0446, 16'h9999, 1'b1, 1'b0, 4};
        vecs[15] = '{1'b0, 1'b1, 16'h9999, 16'h0000, 1'b0, 1'b0, 4};

        bus.in_valid = 1'b0;
        bus.op       = 1'b0;
        bus.clr      = 1'b0;
        bus.operand  = '0;
        rst_n        = 1'b1;

        // Asynchronous reset asserted mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("rst_acc", 32'(bus.acc), 32'h0000);
        check("rst_carry", 32'(bus.carry), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_an", 32'(an), 32'b0001);
        check("rst_seg", 32'(seg), 32'b1111110);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven transactions
        for (int v = 0; v < 16; v++) begin
            run_txn(vecs[v].clr_first, vecs[v].op, vecs[v].operand, lat);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_acc", v), 32'(bus.acc), 32'(vecs[v].exp_acc));
            check($sformatf("v%0d_carry", v), 32'(bus.carry), 32'(vecs[v].exp_carry));
            check($sformatf("v%0d_err", v), 32'(bus.err), 32'(vecs[v].exp_err));
            @(negedge clk);
            check($sformatf("v%0d_pulse", v), 32'(bus.out_valid), 32'd0);
        end

        // in_valid held through ADD, clr pulsed during ADD: neither has any effect
        bus.in_valid = 1'b1;
        bus.op       = 1'b0;
        bus.operand  = 16'h0001;
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            check("busy_in_ready", 32'(bus.in_ready), 32'd0);
            if (n == 1) bus.clr = 1'b1;
            if (n == 2) bus.clr = 1'b0;
            @(negedge clk);
            n++;
        end
        check("busy_latency", 32'(n), 32'd4);
        check("busy_acc", 32'(bus.acc), 32'h0001);
        bus.in_valid = 1'b0;
        count_ov(6, cnt);
        check("busy_no_second", 32'(cnt), 32'd0);
        check("busy_acc_hold", 32'(bus.acc), 32'h0001);

        // clr together with in_valid: cleared, not accepted
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.operand  = 16'h0005;
        #1;
        check("clrv_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        check("clrv_acc", 32'(bus.acc), 32'h0000);
        count_ov(8, cnt);
        check("clrv_no_accept", 32'(cnt), 32'd0);
        check("clrv_acc_hold", 32'(bus.acc), 32'h0000);

        // Display scan of 1234
        run_txn(1'b1, 1'b0, 16'h1234, lat);
        check("scan_acc", 32'(bus.acc), 32'h1234);
        n = 0;
        while (an !== 4'b1000 && n < 40) begin @(negedge clk); n++; end
        while (an !== 4'b0001 && n < 40) begin @(negedge clk); n++; end
        check("scan_sync", 32'(n < 40), 32'd1);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < SCAN_DIV; c++) begin
                check($sformatf("scan_an_d%0d_c%0d", k, c), 32'(an), 32'(4'b0001 << k));
                check($sformatf("scan_seg_d%0d_c%0d", k, c), 32'(seg),
                      32'(seg_tab[(k == 0) ? 4 : (k == 1) ? 3 : (k == 2) ? 2 : 1]));
                @(negedge clk);
            end
        end

        // Reset asserted in the middle of an ADD
        bus.in_valid = 1'b1;
        bus.op       = 1'b0;
        bus.operand  = 16'h0001;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_acc", 32'(bus.acc), 32'h0000);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_an", 32'(an), 32'b0001);
        check("midrst_seg", 32'(seg), 32'b1111110);
        @(negedge clk);
        rst_n = 1'b1;
        count_ov(8, cnt);
        check("midrst_no_ov", 32'(cnt), 32'd0);
        check("midrst_acc_hold", 32'(bus.acc), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
